mlp_train_sequencer: RTL and testbench

Hardware replacement for hand-written epoch loops. It holds a small dataset of fixed-point samples and drives an MLP instance through repeated train/evaluate epochs. After each epoch it scores thresholded classification accuracy and stops after a configured number of epochs, or early when every sample is classified correctly. It sits between a host/loader and the MLP's values/expected/training/prediction ports.

---
 rtl/mlp_train_sequencer_pkg.sv | 23 ++
 rtl/mlp_train_sequencer_if.sv | 26 ++
 rtl/mlp_train_sequencer_pred_align.sv | 51 +++++
 rtl/mlp_train_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_mlp_train_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mlp_train_sequencer_pkg.sv
// Shared types for the MLP training sequencer: Q8.8 signed fixed point,
// FSM state encoding and the thresholded class helper.
package mlp_train_sequencer_pkg;

    typedef logic signed [15:0] sfp;

    localparam sfp ONE  = 16'sh0100;
    localparam sfp HALF = 16'sh0080;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRAIN,
        ST_EVAL,
        ST_DRAIN,
        ST_SCORE,
        ST_DONE
    } seq_state_e;

    function automatic logic sfp_class(sfp v, sfp thr);
        return v >= thr;
    endfunction

endpackage

// File: rtl/mlp_train_sequencer_if.sv
// Values/expected/training/prediction bundle between the sequencer and an MLP.
interface mlp_train_sequencer_if #(
    parameter int INPUTS  = 2,
    parameter int OUTPUTS = 1
);
    import mlp_train_sequencer_pkg::*;

    sfp [INPUTS-1:0]  mlp_values;
    sfp [OUTPUTS-1:0] mlp_expected;
    logic             mlp_training;
    sfp [OUTPUTS-1:0] prediction;

    modport master (
        output mlp_values,
        output mlp_expected,
        output mlp_training,
        input  prediction
    );

    modport slave (
        input  mlp_values,
        input  mlp_expected,
        input  mlp_training,
        output prediction
    );
endinterface

// File: rtl/mlp_train_sequencer_pred_align.sv
// Delay line carrying valid + expected so each expected value meets its
// prediction PRED_LAT cycles after the sample was driven.
module mlp_train_sequencer_pred_align
    import mlp_train_sequencer_pkg::*;
#(
    parameter int OUTPUTS  = 1,
    parameter int PRED_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  sfp [OUTPUTS-1:0] in_expected,
    output logic             out_valid,
    output sfp [OUTPUTS-1:0] out_expected
);
    logic [PRED_LAT-1:0] vld_q, vld_d;
    sfp [OUTPUTS-1:0]    exp_q [PRED_LAT];
    sfp [OUTPUTS-1:0]    exp_d [PRED_LAT];

    always_comb begin
        vld_d    = '0;
        exp_d    = exp_q;
        exp_d[0] = in_expected;
        if (!flush) begin
            vld_d[0] = in_valid;
        end
        for (int i = 1; i < PRED_LAT; i++) begin
            exp_d[i] = exp_q[i-1];
            if (!flush) begin
                vld_d[i] = vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < PRED_LAT; i++) begin
                exp_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            exp_q <= exp_d;
        end
    end

    assign out_valid    = vld_q[PRED_LAT-1];
    assign out_expected = exp_q[PRED_LAT-1];

endmodule

// File: rtl/mlp_train_sequencer.sv
// Dataset store plus train/eval epoch FSM that drives an MLP and scores
// thresholded accuracy, stopping on epoch count or an all-correct pass.
module mlp_train_sequencer
    import mlp_train_sequencer_pkg::*;
#(
    parameter int INPUTS      = 2,
    parameter int OUTPUTS     = 1,
    parameter int NUM_SAMPLES = 4,
    parameter int PRED_LAT    = 1,
    parameter int EPOCH_W     = 16,
    localparam int AW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1,
    localparam int CW = $clog2(NUM_SAMPLES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld_en,
    input  logic [AW-1:0]        ld_addr,
    input  sfp [INPUTS-1:0]      ld_values,
    input  sfp [OUTPUTS-1:0]     ld_expected,
    input  logic                 start,
    input  logic                 abort,
    input  logic [EPOCH_W-1:0]   cfg_epochs,
    input  logic                 early_stop_en,
    input  sfp                   threshold,
    mlp_train_sequencer_if.master mlp,
    output logic                 busy,
    output logic                 done,
    output logic [EPOCH_W-1:0]   epoch_idx,
    output logic [CW-1:0]        last_correct,
    output logic                 all_correct
);
    localparam int DW = (PRED_LAT > 1) ? $clog2(PRED_LAT) : 1;
    localparam logic [AW-1:0] LAST_IDX   = AW'(NUM_SAMPLES - 1);
    localparam logic [CW-1:0] N_CNT      = CW'(NUM_SAMPLES);
    localparam logic [DW-1:0] DRAIN_INIT = DW'(PRED_LAT - 1);

    sfp [INPUTS-1:0]  ds_values_q   [NUM_SAMPLES];
    sfp [OUTPUTS-1:0] ds_expected_q [NUM_SAMPLES];
    logic             ds_we;

    seq_state_e        state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d, epoch_inc;
    logic [EPOCH_W-1:0] cfg_epochs_q, cfg_epochs_d;
    logic              early_q, early_d;
    sfp                thr_q, thr_d;
    logic [CW-1:0]     acc_q, acc_d;
    logic [CW-1:0]     lc_q, lc_d;
    sfp [INPUTS-1:0]   mlp_values_q, mlp_values_d;
    sfp [OUTPUTS-1:0]  mlp_expected_q, mlp_expected_d;
    logic              mlp_training_q, mlp_training_d;

    logic              pa_valid;
    sfp [OUTPUTS-1:0]  pa_expected;
    logic              sample_ok;

    assign busy = (state_q == ST_TRAIN) || (state_q == ST_EVAL) ||
                  (state_q == ST_DRAIN) || (state_q == ST_SCORE);
    assign done = (state_q == ST_DONE);

    // Dataset is deliberately left without reset; it is reloaded by the host.
    assign ds_we = ld_en && !busy && (32'(ld_addr) < NUM_SAMPLES);

    always_ff @(posedge clk) begin
        if (ds_we) begin
            ds_values_q[ld_addr]   <= ld_values;
            ds_expected_q[ld_addr] <= ld_expected;
        end
    end

    mlp_train_sequencer_pred_align #(
        .OUTPUTS  (OUTPUTS),
        .PRED_LAT (PRED_LAT)
    ) u_pred_align (
        .clk          (clk),
        .rst          (rst),
        .flush        (abort),
        .in_valid     (state_q == ST_EVAL),
        .in_expected  (mlp_expected_q),
        .out_valid    (pa_valid),
        .out_expected (pa_expected)
    );

    always_comb begin
        sample_ok = 1'b1;
        for (int k = 0; k < OUTPUTS; k++) begin
            if (sfp_class(mlp.prediction[k], thr_q) != sfp_class(pa_expected[k], thr_q)) begin
                sample_ok = 1'b0;
            end
        end
    end

    assign epoch_inc = epoch_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        drain_d        = drain_q;
        epoch_d        = epoch_q;
        cfg_epochs_d   = cfg_epochs_q;
        early_d        = early_q;
        thr_d          = thr_q;
        acc_d          = acc_q;
        lc_d           = lc_q;
        mlp_values_d   = mlp_values_q;
        mlp_expected_d = mlp_expected_q;
        mlp_training_d = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            acc_d   = '0;
        end else begin
            if (pa_valid && sample_ok) begin
                acc_d = acc_q + 1'b1;
            end
            // Outputs are loaded with the sample the next state will present,
            // so the registered drive lines up with state_q/idx_q.
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        epoch_d = '0;
                        if (cfg_epochs == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d        = ST_TRAIN;
                            cfg_epochs_d   = cfg_epochs;
                            early_d        = early_stop_en;
                            thr_d          = threshold;
                            acc_d          = '0;
                            idx_d          = '0;
                            mlp_values_d   = ds_values_q[0];
                            mlp_expected_d = ds_expected_q[0];
                            mlp_training_d = 1'b1;
                        end
                    end
                end
                ST_TRAIN: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_EVAL;
                        idx_d   = '0;
                    end else begin
                        idx_d          = idx_q + 1'b1;
                        mlp_training_d = 1'b1;
                    end
                    mlp_values_d   = ds_values_q[idx_d];
                    mlp_expected_d = ds_expected_q[idx_d];
                end
                ST_EVAL: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_INIT;
                    end else begin
                        idx_d          = idx_q + 1'b1;
                        mlp_values_d   = ds_values_q[idx_d];
                        mlp_expected_d = ds_expected_q[idx_d];
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == '0) begin
                        state_d = ST_SCORE;
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
                ST_SCORE: begin
                    lc_d    = acc_q;
                    epoch_d = epoch_inc;
                    if ((epoch_inc == cfg_epochs_q) || (early_q && (acc_q == N_CNT))) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d        = ST_TRAIN;
                        acc_d          = '0;
                        idx_d          = '0;
                        mlp_values_d   = ds_values_q[0];
                        mlp_expected_d = ds_expected_q[0];
                        mlp_training_d = 1'b1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            drain_q        <= '0;
            epoch_q        <= '0;
            cfg_epochs_q   <= '0;
            early_q        <= 1'b0;
            thr_q          <= '0;
            acc_q          <= '0;
            lc_q           <= '0;
            mlp_values_q   <= '0;
            mlp_expected_q <= '0;
            mlp_training_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            drain_q        <= drain_d;
            epoch_q        <= epoch_d;
            cfg_epochs_q   <= cfg_epochs_d;
            early_q        <= early_d;
            thr_q          <= thr_d;
            acc_q          <= acc_d;
            lc_q           <= lc_d;
            mlp_values_q   <= mlp_values_d;
            mlp_expected_q <= mlp_expected_d;
            mlp_training_q <= mlp_training_d;
        end
    end

    assign mlp.mlp_values   = mlp_values_q;
    assign mlp.mlp_expected = mlp_expected_q;
    assign mlp.mlp_training = mlp_training_q;

    assign epoch_idx    = epoch_q;
    assign last_correct = lc_q;
    assign all_correct  = (lc_q == N_CNT);

endmodule

// File: tb/tb_mlp_train_sequencer.sv
// Scoreboard bench: two sequencers (PRED_LAT 1 and 3) driving MLP stubs on an
// XOR dataset; run results are checked by a monitor on each done pulse.
module tb_mlp_train_sequencer;
    import mlp_train_sequencer_pkg::*;

    localparam sfp NEG_ONE  = 16'shFF00;
    localparam sfp NEG_HALF = 16'shFF80;

    typedef struct {
        int epochs;
        int lc;
        int ac;
        int busy_cyc;
        int train_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ld_en_a = 1'b0, ld_en_b = 1'b0;
    logic [1:0] ld_addr = '0;
    sfp [1:0] ld_values = '0;
    sfp [0:0] ld_expected = '0;
    logic start_a = 1'b0, start_b = 1'b0;
    logic abort_a = 1'b0, abort_b = 1'b0;
    logic [15:0] cfg_epochs = '0;
    logic early = 1'b0;
    sfp threshold = HALF;

    logic busy_a, done_a, ac_a, busy_b, done_b, ac_b;
    logic [15:0] ep_a, ep_b;
    logic [2:0] lc_a, lc_b;

    int n_vec = 0;
    int n_err = 0;
    int stub_mode = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    int bc_a = 0, tc_a = 0, bc_b = 0, tc_b = 0;

    sfp [0:0] pred_a;
    sfp [0:0] pb1, pb2, pb3;

    mlp_train_sequencer_if #(.INPUTS(2), .OUTPUTS(1)) if_a ();
    mlp_train_sequencer_if #(.INPUTS(2), .OUTPUTS(1)) if_b ();

    mlp_train_sequencer #(.PRED_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .ld_en(ld_en_a), .ld_addr(ld_addr),
        .ld_values(ld_values), .ld_expected(ld_expected),
        .start(start_a), .abort(abort_a), .cfg_epochs(cfg_epochs),
        .early_stop_en(early), .threshold(threshold), .mlp(if_a),
        .busy(busy_a), .done(done_a), .epoch_idx(ep_a),
        .last_correct(lc_a), .all_correct(ac_a)
    );

    mlp_train_sequencer #(.PRED_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .ld_en(ld_en_b), .ld_addr(ld_addr),
        .ld_values(ld_values), .ld_expected(ld_expected),
        .start(start_b), .abort(abort_b), .cfg_epochs(cfg_epochs),
        .early_stop_en(early), .threshold(threshold), .mlp(if_b),
        .busy(busy_b), .done(done_b), .epoch_idx(ep_b),
        .last_correct(lc_b), .all_correct(ac_b)
    );

    always #5 clk = ~clk;

    // Stub MLP: 0 = ideal XOR answer, 1 = constant 0, 2 = constant -1.0
    function automatic sfp stub_f(sfp [1:0] v, int mode);
        if (mode == 0) return ((v[0] >= HALF) ^ (v[1] >= HALF)) ? ONE : 16'sh0000;
        if (mode == 1) return 16'sh0000;
        return NEG_ONE;
    endfunction

    always @(posedge clk) begin
        pred_a[0] <= stub_f(if_a.mlp_values, stub_mode);
        pb1[0]    <= stub_f(if_b.mlp_values, stub_mode);
        pb2       <= pb1;
        pb3       <= pb2;
    end
    assign if_a.prediction = pred_a;
    assign if_b.prediction = pb3;

    task automatic chk(string name, int act, int expv);
        n_vec++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic check_done(int d, int ep, int lc, int ac, int bc, int tc);
        exp_t e;
        if ((d == 0 && q_a.size() == 0) || (d == 1 && q_b.size() == 0)) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done dut%0d: got done pulse, expected none", d);
        end else begin
            if (d == 0) e = q_a.pop_front();
            else        e = q_b.pop_front();
            chk($sformatf("dut%0d_epoch_idx", d), ep, e.epochs);
            chk($sformatf("dut%0d_last_correct", d), lc, e.lc);
            chk($sformatf("dut%0d_all_correct", d), ac, e.ac);
            chk($sformatf("dut%0d_busy_cycles", d), bc, e.busy_cyc);
            chk($sformatf("dut%0d_train_cycles", d), tc, e.train_cyc);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst || start_a) begin
                bc_a = 0;
                tc_a = 0;
            end else begin
                if (busy_a) bc_a++;
                if (if_a.mlp_training) tc_a++;
            end
            if (rst || start_b) begin
                bc_b = 0;
                tc_b = 0;
            end else begin
                if (busy_b) bc_b++;
                if (if_b.mlp_training) tc_b++;
            end
            if (done_a) check_done(0, int'(ep_a), int'(lc_a), int'(ac_a), bc_a, tc_a);
            if (done_b) check_done(1, int'(ep_b), int'(lc_b), int'(ac_b), bc_b, tc_b);
        end
    end

    task automatic load(int addr, sfp v0, sfp v1, sfp e, bit to_a, bit to_b);
        ld_addr        = 2'(addr);
        ld_values[0]   = v0;
        ld_values[1]   = v1;
        ld_expected[0] = e;
        ld_en_a        = to_a;
        ld_en_b        = to_b;
        @(posedge clk); #1;
        ld_en_a = 1'b0;
        ld_en_b = 1'b0;
    endtask

    task automatic kick(int d, int cfg, bit es, sfp thr, int mode);
        stub_mode  = mode;
        cfg_epochs = 16'(cfg);
        early      = es;
        threshold  = thr;
        if (d == 0) start_a = 1'b1;
        else        start_b = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(int d);
        int n = 0;
        while (!((d == 0) ? done_a : done_b) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 2000) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout dut%0d: no done within %0d cycles", d, n);
        end
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    // Epoch = 2*N + PRED_LAT + 1 busy cycles: 10 for PRED_LAT=1, 12 for PRED_LAT=3.
    task automatic run(int d, int cfg, bit es, sfp thr, int mode, exp_t e, bit ld_busy);
        if (d == 0) q_a.push_back(e);
        else        q_b.push_back(e);
        kick(d, cfg, es, thr, mode);
        if (ld_busy) load(0, ONE, ONE, ONE, 1'b1, 1'b0);
        wait_done(d);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_busy", int'(busy_a), 0);
        chk("reset_done", int'(done_a), 0);
        chk("reset_epoch_idx", int'(ep_a), 0);
        chk("reset_last_correct", int'(lc_a), 0);
        chk("reset_all_correct", int'(ac_a), 0);
        chk("reset_training", int'(if_a.mlp_training), 0);
        chk("reset_values0", int'(if_a.mlp_values[0]), 0);

        load(0, 16'sh0000, 16'sh0000, 16'sh0000, 1'b1, 1'b1);
        load(1, 16'sh0000, ONE,       ONE,       1'b1, 1'b1);
        load(2, ONE,       16'sh0000, ONE,       1'b1, 1'b1);
        load(3, ONE,       ONE,       16'sh0000, 1'b1, 1'b1);

        run(0, 100, 1'b1, HALF, 0, '{1, 4, 1, 10, 4}, 1'b1);
        run(0, 3, 1'b1, HALF, 1, '{3, 2, 0, 30, 12}, 1'b0);

        kick(0, 100, 1'b1, HALF, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_pre_busy", int'(busy_a), 1);
        chk("abort_pre_training", int'(if_a.mlp_training), 0);
        abort_a = 1'b1;
        @(posedge clk); #1;
        abort_a = 1'b0;
        chk("abort_busy", int'(busy_a), 0);
        chk("abort_training", int'(if_a.mlp_training), 0);
        chk("abort_done", int'(done_a), 0);
        chk("abort_last_correct", int'(lc_a), 2);
        repeat (20) @(posedge clk);
        #1;
        chk("abort_idle_busy", int'(busy_a), 0);

        run(0, 100, 1'b1, HALF, 0, '{1, 4, 1, 10, 4}, 1'b0);
        run(0, 0, 1'b1, HALF, 0, '{0, 4, 1, 0, 0}, 1'b0);
        run(0, 1, 1'b0, NEG_HALF, 2, '{1, 0, 0, 10, 4}, 1'b0);
        run(0, 2, 1'b0, HALF, 0, '{2, 4, 1, 20, 8}, 1'b0);
        run(1, 100, 1'b1, HALF, 0, '{1, 4, 1, 12, 4}, 1'b0);

        kick(0, 100, 1'b1, HALF, 0);
        @(posedge clk); #2;
        chk("pre_rst_training", int'(if_a.mlp_training), 1);
        chk("pre_rst_values1", int'(if_a.mlp_values[1]), int'(ONE));
        rst = 1'b1;
        #1;
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_training", int'(if_a.mlp_training), 0);
        chk("rst_values1", int'(if_a.mlp_values[1]), 0);
        chk("rst_last_correct", int'(lc_a), 0);
        chk("rst_all_correct", int'(ac_a), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_busy", int'(busy_a), 0);
        chk("post_rst_done", int'(done_a), 0);
        chk("queue_a_empty", q_a.size(), 0);
        chk("queue_b_empty", q_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
